qbus_cycle: RTL and testbench

Bus cycle sequencer between the LSI-11 datapath and the external Q-bus-style memory/peripheral bus. It accepts one read or write request at a time (address, write data, byte flag), runs the SYNC/DIN/DOUT/RPLY handshake, and returns the read word for the datapath's `dbi` input. It reports completion and bus errors (odd word address, RPLY timeout) to the control unit, which raises the bus-error trap.

---
 rtl/qbus_pkg.sv | 18 +
 rtl/qbus_cycle_rply_sync.sv | 27 ++
 rtl/qbus_cycle.sv | 123 ++++++++++++
 tb/tb_qbus_cycle.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// Shared definitions for the Q-bus cycle sequencer: FSM encoding, default timeout, write-lane helper.
// Latency: n/a (constants and a combinational function only).
// Backpressure: n/a.
package qbus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_END  = 2'd3;

  localparam int QBUS_TIMEOUT_DEF = 64;

  // Byte writes put the low byte on both lanes so the slave can pick either half by addr[0].
  function automatic logic [15:0] wr_lanes(input logic [15:0] d, input logic is_byte);
    return is_byte ? {d[7:0], d[7:0]} : d;
  endfunction

endpackage

// File: rtl/qbus_cycle_rply_sync.sv
// Two-flop synchronizer bringing the slave's asynchronous RPLY into the clk domain.
// Latency: 2 clk edges from input change to output change.
// Backpressure: none; free-running.
module rply_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; only r_sync is safe to use in the FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/qbus_cycle.sv
// Q-bus cycle sequencer: one read/write per request, SYNC/DIN/DOUT/RPLY handshake, odd-address and RPLY-timeout errors.
// Latency: odd-address error 1 edge; normal cycle done 3 edges after RPLY rises into DATA+sync; timeout TIMEOUT+1 cycles in DATA.
// Backpressure: busy is high outside IDLE and req is ignored then; requester holds req low until done.
module qbus_cycle
  import qbus_pkg::*;
#(
  parameter int TIMEOUT = QBUS_TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic        i_byte,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_buserr,
  output logic [15:0] o_bus_addr,
  output logic [15:0] o_bus_dout,
  input  logic [15:0] i_bus_din,
  output logic        o_bus_sync,
  output logic        o_bus_dinstb,
  output logic        o_bus_doutstb,
  output logic        o_bus_wtbt,
  input  logic        i_bus_rply
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic        r_byte;
  logic [15:0] r_bus_addr;
  logic [15:0] r_bus_dout;
  logic [15:0] r_rdata;
  logic        r_done;
  logic        r_buserr;
  logic        w_rply_s;

  rply_sync u_rply_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_async (i_bus_rply),
    .o_sync  (w_rply_s)
  );

  // Cycle FSM with its latched request, timeout counter, read capture and one-cycle status pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_we       <= 1'b0;
      r_byte     <= 1'b0;
      r_bus_addr <= 16'd0;
      r_bus_dout <= 16'd0;
      r_rdata    <= 16'd0;
      r_done     <= 1'b0;
      r_buserr   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_buserr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            if (i_addr[0] && !i_byte) begin
              // Odd word address never reaches the bus.
              r_done   <= 1'b1;
              r_buserr <= 1'b1;
            end else begin
              r_bus_addr <= i_addr;
              r_we       <= i_we;
              r_byte     <= i_byte;
              r_bus_dout <= wr_lanes(i_wdata, i_byte);
              r_state    <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          r_cnt   <= 8'd0;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          // RPLY is checked first so a reply on the timeout edge still completes normally.
          if (w_rply_s) begin
            if (!r_we) begin
              r_rdata <= i_bus_din;
            end
            r_done  <= 1'b1;
            r_state <= ST_END;
          end else if (r_cnt == LP_TIMEOUT) begin
            r_done   <= 1'b1;
            r_buserr <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_END: begin
          if (!w_rply_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign o_busy        = (r_state != ST_IDLE);
  assign o_bus_sync    = (r_state != ST_IDLE);
  assign o_bus_dinstb  = (r_state == ST_DATA) && !r_we;
  assign o_bus_doutstb = (r_state == ST_DATA) && r_we;
  assign o_bus_wtbt    = (r_state == ST_ADDR) && r_we && r_byte;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_dout    = r_bus_dout;
  assign o_rdata       = r_rdata;
  assign o_done        = r_done;
  assign o_buserr      = r_buserr;

endmodule

// File: tb/tb_qbus_cycle.sv
// Testbench for qbus_cycle: directed cases plus randomized bus cycles against a transaction-level timing model.
module tb_qbus_cycle;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        byt = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [15:0] wdata = 16'd0;
  logic [15:0] din = 16'd0;
  logic        rply = 1'b0;

  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        buserr;
  logic [15:0] bus_addr;
  logic [15:0] bus_dout;
  logic        sync;
  logic        dinstb;
  logic        doutstb;
  logic        wtbt;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_rdata = 16'd0;

  qbus_cycle #(.TIMEOUT(TO)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_req         (req),
    .i_we          (we),
    .i_byte        (byt),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_rdata       (rdata),
    .o_busy        (busy),
    .o_done        (done),
    .o_buserr      (buserr),
    .o_bus_addr    (bus_addr),
    .o_bus_dout    (bus_dout),
    .i_bus_din     (din),
    .o_bus_sync    (sync),
    .o_bus_dinstb  (dinstb),
    .o_bus_doutstb (doutstb),
    .o_bus_wtbt    (wtbt),
    .i_bus_rply    (rply)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request. t_nr: cycles after acceptance at which the slave raises RPLY (>= 1).
  // t_hold: extra cycles RPLY stays high after done. t_early: raise the next req during END.
  task automatic do_txn(input logic t_we, input logic t_byte, input logic [15:0] t_addr,
                        input logic [15:0] t_wdata, input logic [15:0] t_din,
                        input int t_nr, input int t_hold, input logic t_early);
    logic        odd;
    logic        is_to;
    int          n_exp;
    logic [15:0] exp_dout;
    odd      = t_addr[0] & ~t_byte;
    exp_dout = t_byte ? {t_wdata[7:0], t_wdata[7:0]} : t_wdata;
    // RPLY seen 3 edges after it rises; timeout fires TO+1 cycles into DATA (DATA starts 1 edge after accept).
    is_to    = (t_nr + 3 > TO + 2);
    n_exp    = is_to ? TO + 2 : t_nr + 3;

    req = 1'b1; we = t_we; byt = t_byte; addr = t_addr; wdata = t_wdata; din = t_din; rply = 1'b0;
    tick;
    req = 1'b0;
    if (odd) begin
      chk1("odd_done", done, 1'b1);
      chk1("odd_buserr", buserr, 1'b1);
      chk1("odd_sync", sync, 1'b0);
      chk1("odd_busy", busy, 1'b0);
      tick;
      chk1("odd_done_once", done, 1'b0);
      chk1("odd_buserr_once", buserr, 1'b0);
      chk16("odd_rdata", rdata, exp_rdata);
      return;
    end
    chk1("addr_sync", sync, 1'b1);
    chk1("addr_busy", busy, 1'b1);
    chk1("addr_wtbt", wtbt, t_we & t_byte);
    chk1("addr_dinstb", dinstb, 1'b0);
    chk16("addr_bus_addr", bus_addr, t_addr);
    chk16("addr_bus_dout", bus_dout, exp_dout);
    for (int n = 1; n < n_exp; n++) begin
      tick;
      chk1("data_dinstb", dinstb, ~t_we);
      chk1("data_doutstb", doutstb, t_we);
      chk1("data_sync", sync, 1'b1);
      chk1("data_done", done, 1'b0);
      if (n == t_nr) rply = 1'b1;
    end
    tick;
    chk1("done_pulse", done, 1'b1);
    chk1("done_buserr", buserr, is_to);
    chk1("done_dinstb", dinstb, 1'b0);
    chk1("done_doutstb", doutstb, 1'b0);
    if (is_to) begin
      chk1("to_sync", sync, 1'b0);
      rply = 1'b0;
      tick;
      chk1("to_done_once", done, 1'b0);
      chk1("to_busy", busy, 1'b0);
      chk16("to_rdata", rdata, exp_rdata);
      tick; tick; tick;
    end else begin
      if (!t_we) exp_rdata = t_din;
      chk16("end_rdata", rdata, exp_rdata);
      chk1("end_sync", sync, 1'b1);
      for (int h = 0; h < t_hold; h++) begin
        tick;
        chk1("end_hold_sync", sync, 1'b1);
        chk1("end_hold_done", done, 1'b0);
        chk1("end_hold_strb", dinstb | doutstb, 1'b0);
      end
      rply = 1'b0;
      if (t_early) begin
        req = 1'b1; we = ~t_we; addr = ~t_addr;
      end
      tick;
      chk1("end_busy1", busy, 1'b1);
      chk1("end_done_once", done, 1'b0);
      tick;
      chk1("end_busy2", busy, 1'b1);
      chk16("end_no_accept", bus_addr, t_addr);
      tick;
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_sync", sync, 1'b0);
      chk16("idle_rdata", rdata, exp_rdata);
    end
  endtask

  initial begin
    // Reset values.
    #12;
    chk1("rst_sync", sync, 1'b0);
    chk1("rst_dinstb", dinstb, 1'b0);
    chk1("rst_doutstb", doutstb, 1'b0);
    chk1("rst_wtbt", wtbt, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_buserr", buserr, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk16("rst_bus_addr", bus_addr, 16'd0);
    chk16("rst_bus_dout", bus_dout, 16'd0);
    chk16("rst_rdata", rdata, 16'd0);
    tick;
    rst_n = 1'b1;
    tick; tick;

    // Word read, reply after 3 cycles.
    do_txn(1'b0, 1'b0, 16'o001000, 16'h0000, 16'o123456, 3, 0, 1'b0);
    // Byte write to odd byte address.
    do_txn(1'b1, 1'b1, 16'o001001, 16'h00A5, 16'h0000, 2, 1, 1'b0);
    // Odd word address.
    do_txn(1'b0, 1'b0, 16'o000003, 16'h0000, 16'hFFFF, 3, 0, 1'b0);
    // Timeout with no reply at all.
    do_txn(1'b0, 1'b0, 16'o002000, 16'h0000, 16'h1111, 1000, 0, 1'b0);
    // Reply judged on the timeout edge wins; one cycle later loses.
    do_txn(1'b0, 1'b0, 16'o002002, 16'h0000, 16'h2222, TO - 1, 0, 1'b0);
    do_txn(1'b0, 1'b0, 16'o002004, 16'h0000, 16'h3333, TO, 0, 1'b0);

    // Reset while in DATA.
    req = 1'b1; we = 1'b0; byt = 1'b0; addr = 16'o003000;
    tick;
    req = 1'b0;
    tick; tick; tick;
    rply = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_sync", sync, 1'b0);
    chk1("mid_rst_dinstb", dinstb, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    exp_rdata = 16'd0;
    chk16("mid_rst_rdata", rdata, exp_rdata);
    tick;
    chk1("mid_rst_done2", done, 1'b0);
    rply = 1'b0;
    rst_n = 1'b1;
    tick; tick;
    do_txn(1'b0, 1'b0, 16'o003000, 16'h0000, 16'o777001, 2, 0, 1'b0);

    // Back-to-back: next req raised during a slow END.
    do_txn(1'b0, 1'b0, 16'o004000, 16'h0000, 16'hBEEF, 1, 3, 1'b1);
    do_txn(1'b0, 1'b0, 16'o004002, 16'h0000, 16'hCAFE, 2, 0, 1'b0);

    // Randomized cycles.
    for (int i = 0; i < 24; i++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
             16'($urandom), 16'($urandom), int'($urandom_range(1, TO + 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    req = 1'b0;
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
